// File: rtl/sprite_pkg.sv
// Shared sprite types for the scanline evaluator and the sprite drawer.
//   oam_entry_t   : one OAM word, field layout as stored in sprite memory
//   second_slot_t : one secondary-array slot {OAM address, active}
//   SPRITE_HEIGHT : sprite height in lines
package sprite_pkg;

   localparam int unsigned SPRITE_HEIGHT = 16;
   localparam int unsigned OAM_ADDR_W    = 8;
   localparam int unsigned YPOS_W        = 10;
   localparam int unsigned XPOS_W        = 10;
   localparam int unsigned SPRITEREF_W   = 8;
   // One bit wider than ypos so that ypos + SPRITE_HEIGHT cannot wrap.
   localparam int unsigned HIT_ARITH_W   = YPOS_W + 1;

   typedef struct packed {
      logic                   enable;
      logic                   yflip;
      logic                   xflip;
      logic                   prio;
      logic [YPOS_W-1:0]      ypos;
      logic [XPOS_W-1:0]      xpos;
      logic [SPRITEREF_W-1:0] spriteref;
   } oam_entry_t;

   typedef struct packed {
      logic [OAM_ADDR_W-1:0] addr;
      logic                  active;
   } second_slot_t;

endpackage

// File: rtl/sprite_line_hit.sv
// Combinational vertical hit test of one OAM entry against a scanline.
//   entry : OAM word (only enable and ypos matter)
//   line  : scanline under evaluation
//   hit_c : enable && ypos <= line < ypos + SPRITE_HEIGHT
module sprite_line_hit
   import sprite_pkg::*;
#(
   parameter int unsigned LINE_NUMBER_WIDTH = 9
) (
   input  oam_entry_t                   entry,
   input  logic [LINE_NUMBER_WIDTH-1:0] line,
   output logic                         hit_c
);

   localparam int unsigned AW = HIT_ARITH_W;

   logic [AW-1:0] top_c;
   logic [AW-1:0] bot_c;
   logic [AW-1:0] line_c;
   logic          unused_fields_c;

   // Widened compare: a ypos near the top of its range never wraps onto line 0.
   always_comb begin
      top_c  = AW'(entry.ypos);
      bot_c  = top_c + AW'(SPRITE_HEIGHT);
      line_c = AW'(line);
      hit_c  = entry.enable && (line_c >= top_c) && (line_c < bot_c);
   end

   // Horizontal and attribute fields belong to the drawer.
   assign unused_fields_c = ^{entry.yflip, entry.xflip, entry.prio,
                              entry.xpos, entry.spriteref};

endmodule

// File: rtl/sprite_evaluator.sv
// Per-scanline sprite selection: scans every OAM entry in address order and
// collects the entries covering the requested line into the secondary array.
//   start/line_number : request evaluation of a line (ignored while busy)
//   busy/done         : busy from accepted start; done pulses once results valid
//   oam_a/oam_d       : shared OAM read port (1-cycle latency), oam_a 'z when idle
//   second_array      : slot i = {OAM address, active}, filled in address order
//   sprite_count      : number of active slots
//   overflow          : more hits than slots; scan stops at the first extra hit
module sprite_evaluator
   import sprite_pkg::*;
#(
   parameter int unsigned OAM_ADDR_SIZE     = 8,
   parameter int unsigned OAM_DATA_SIZE     = 32,
   parameter int unsigned SECOND_ARRAY_SIZE = 32,
   parameter int unsigned DISPLAY_HEIGHT    = 480,
   parameter int unsigned LINE_NUMBER_WIDTH = $clog2(DISPLAY_HEIGHT)
) (
   input  logic                                            clk,
   input  logic                                            rst_n,
   input  logic                                            start,
   input  logic [LINE_NUMBER_WIDTH-1:0]                    line_number,
   output logic                                            busy,
   output logic                                            done,
   output logic [OAM_ADDR_SIZE-1:0]                        oam_a,
   input  logic [OAM_DATA_SIZE-1:0]                        oam_d,
   output logic [SECOND_ARRAY_SIZE-1:0][OAM_ADDR_SIZE:0]   second_array,
   output logic [$clog2(SECOND_ARRAY_SIZE):0]              sprite_count,
   output logic                                            overflow
);

   localparam int unsigned CNT_W  = $clog2(SECOND_ARRAY_SIZE) + 1;
   localparam int unsigned IDX_W  = CNT_W - 1;
   localparam int unsigned SLOT_W = OAM_ADDR_SIZE + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]                              state_q, state_d;
   logic                                    busy_q, busy_d;
   logic                                    done_q, done_d;
   logic [LINE_NUMBER_WIDTH-1:0]            line_q, line_d;
   logic [OAM_ADDR_SIZE-1:0]                addr_q, addr_d;
   logic                                    vld_q, vld_d;
   logic [OAM_ADDR_SIZE-1:0]                tag_q, tag_d;
   logic [SECOND_ARRAY_SIZE-1:0][SLOT_W-1:0] slots_q, slots_d;
   logic [CNT_W-1:0]                        count_q, count_d;
   logic                                    ovf_q, ovf_d;

   oam_entry_t       entry_c;
   logic             hit_c;
   logic [IDX_W-1:0] idx_c;

   assign entry_c = oam_entry_t'(oam_d);
   assign idx_c   = count_q[IDX_W-1:0];

   sprite_line_hit #(
      .LINE_NUMBER_WIDTH (LINE_NUMBER_WIDTH)
   ) u_hit (
      .entry (entry_c),
      .line  (line_q),
      .hit_c (hit_c)
   );

   // State register and datapath flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         line_q  <= '0;
         addr_q  <= '0;
         vld_q   <= 1'b0;
         tag_q   <= '0;
         slots_q <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         line_q  <= line_d;
         addr_q  <= addr_d;
         vld_q   <= vld_d;
         tag_q   <= tag_d;
         slots_q <= slots_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state, address sequencing and slot writer.
   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      line_d  = line_q;
      addr_d  = addr_q;
      vld_d   = 1'b0;
      tag_d   = tag_q;
      slots_d = slots_q;
      count_d = count_q;
      ovf_d   = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               line_d  = line_number;
               slots_d = '0;
               count_d = '0;
               ovf_d   = 1'b0;
               busy_d  = 1'b1;
               addr_d  = '0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            // Address issued this cycle returns data next cycle under tag_q.
            vld_d  = 1'b1;
            tag_d  = addr_q;
            addr_d = addr_q + OAM_ADDR_SIZE'(1);
            if (addr_q == '1) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Returned word: append on hit, or stop the scan when all slots are full.
      if (vld_q && hit_c) begin
         if (count_q == CNT_W'(SECOND_ARRAY_SIZE)) begin
            ovf_d   = 1'b1;
            vld_d   = 1'b0;
            state_d = S_DONE;
         end else begin
            slots_d[idx_c] = {tag_q, 1'b1};
            count_d        = count_q + CNT_W'(1);
         end
      end

      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
         done_d = 1'b1;
         busy_d = 1'b0;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign second_array = slots_q;
   assign sprite_count = count_q;
   assign overflow     = ovf_q;
   // The OAM bus is shared with the drawer; release it outside the scan.
   assign oam_a        = (state_q == S_SCAN) ? addr_q : 'z;

endmodule
